mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 243 ++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage: issues one data-bus access per load/store, aligns load data and
// registers the writeback bundle. Optional bus-wait timeout enabled by DMEM_TIMEOUT_EN.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_mem_rd,
    input  logic        ex_mem_wr,
    input  logic [1:0]  ex_mem_size,
    input  logic        ex_mem_unsigned,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd_addr,
    input  logic [11:0] ex_csr_addr,
    input  logic [31:0] ex_csr_wdata,
    input  logic        ex_trap_valid,
    input  logic [31:0] ex_trap_mcause,
    input  logic [31:0] ex_pc,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_q_valid,
    output logic        wb_q_trap_valid,
    output logic [31:0] wb_q_trap_mcause,
    output logic [31:0] wb_q_trap_pc,
    output logic [31:0] wb_q_rd_wdata,
    output logic [31:0] wb_q_csr_wdata,
    output logic [4:0]  wb_q_rd_addr,
    output logic [11:0] wb_q_csr_addr
);

    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t      state_r;
    state_t      state_s;
    logic        alu_s;
    logic        start_s;
    logic        done_s;
    logic        trap_s;
    logic [31:0] cause_s;
    logic        timeout_s;
    logic        is_mem_s;
    logic        misalign_s;

    logic [4:0]  req_rd_addr_r;
    logic [1:0]  req_size_r;
    logic [1:0]  req_off_r;
    logic        req_uns_r;
    logic [31:0] req_pc_r;

    function automatic logic [3:0] wstrb_f(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   wstrb_f = 4'b0001 << off;
            2'b01:   wstrb_f = 4'b0011 << off;
            default: wstrb_f = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wdata_f(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'b00:   wdata_f = {4{data[7:0]}};
            2'b01:   wdata_f = {2{data[15:0]}};
            default: wdata_f = data;
        endcase
    endfunction

    function automatic logic misalign_f(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   misalign_f = 1'b0;
            2'b01:   misalign_f = off[0];
            default: misalign_f = (off != 2'b00);
        endcase
    endfunction

    function automatic logic [31:0] load_ext_f(input logic [1:0] size, input logic [1:0] off,
                                               input logic uns, input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(rdata >> {off, 3'b000});
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'b00:   load_ext_f = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   load_ext_f = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: load_ext_f = rdata;
        endcase
    endfunction

    assign is_mem_s   = ex_mem_rd | ex_mem_wr;
    assign misalign_s = misalign_f(ex_mem_size, ex_addr[1:0]);
    assign mem_stall  = (state_r == BUSY);

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] busy_cnt_r;

    // Count cycles spent waiting in BUSY; restarts with every new bus request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt_r <= {CNT_W{1'b0}};
        end else if (start_s) begin
            busy_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == BUSY) begin
            busy_cnt_r <= busy_cnt_r + CNT_W'(1);
        end
    end

    assign timeout_s = (state_r == BUSY) && (busy_cnt_r == CNT_LAST);
`else
    assign timeout_s = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and per-cycle action decode
    always_comb begin
        state_s = state_r;
        alu_s   = 1'b0;
        start_s = 1'b0;
        done_s  = 1'b0;
        trap_s  = 1'b0;
        cause_s = 32'd0;
        case (state_r)
            IDLE: begin
                if (!ex_valid) begin
                    state_s = IDLE;
                end else if (ex_trap_valid) begin
                    trap_s  = 1'b1;
                    cause_s = ex_trap_mcause;
                end else if (!is_mem_s) begin
                    alu_s = 1'b1;
                end else if (misalign_s) begin
                    trap_s  = 1'b1;
                    cause_s = ex_mem_wr ? 32'd6 : 32'd4;
                end else begin
                    start_s = 1'b1;
                    state_s = BUSY;
                end
            end
            BUSY: begin
                // An ack on the final timeout cycle still completes the access
                if (dmem_ack) begin
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else if (timeout_s) begin
                    trap_s  = 1'b1;
                    cause_s = dmem_we ? 32'd7 : 32'd5;
                    state_s = IDLE;
                end else begin
                    state_s = BUSY;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Bus request registers and writeback bundle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req         <= 1'b0;
            dmem_we          <= 1'b0;
            dmem_addr        <= 32'd0;
            dmem_wdata       <= 32'd0;
            dmem_wstrb       <= 4'd0;
            wb_q_valid       <= 1'b0;
            wb_q_trap_valid  <= 1'b0;
            wb_q_trap_mcause <= 32'd0;
            wb_q_trap_pc     <= 32'd0;
            wb_q_rd_wdata    <= 32'd0;
            wb_q_csr_wdata   <= 32'd0;
            wb_q_rd_addr     <= 5'd0;
            wb_q_csr_addr    <= 12'd0;
            req_rd_addr_r    <= 5'd0;
            req_size_r       <= 2'd0;
            req_off_r        <= 2'd0;
            req_uns_r        <= 1'b0;
            req_pc_r         <= 32'd0;
        end else begin
            wb_q_valid      <= 1'b0;
            wb_q_trap_valid <= 1'b0;
            if (alu_s) begin
                wb_q_valid       <= 1'b1;
                wb_q_trap_mcause <= 32'd0;
                wb_q_trap_pc     <= ex_pc;
                wb_q_rd_addr     <= ex_rd_addr;
                wb_q_rd_wdata    <= ex_addr;
                wb_q_csr_addr    <= ex_csr_addr;
                wb_q_csr_wdata   <= ex_csr_wdata;
            end else if (trap_s) begin
                wb_q_valid       <= 1'b1;
                wb_q_trap_valid  <= 1'b1;
                wb_q_trap_mcause <= cause_s;
                wb_q_trap_pc     <= (state_r == BUSY) ? req_pc_r : ex_pc;
                wb_q_rd_addr     <= 5'd0;
                wb_q_rd_wdata    <= 32'd0;
                wb_q_csr_addr    <= 12'd0;
                wb_q_csr_wdata   <= 32'd0;
                dmem_req         <= 1'b0;
                dmem_we          <= 1'b0;
            end else if (start_s) begin
                dmem_req      <= 1'b1;
                dmem_we       <= ex_mem_wr;
                dmem_addr     <= {ex_addr[31:2], 2'b00};
                dmem_wdata    <= wdata_f(ex_mem_size, ex_store_data);
                dmem_wstrb    <= wstrb_f(ex_mem_size, ex_addr[1:0]);
                req_rd_addr_r <= ex_rd_addr;
                req_size_r    <= ex_mem_size;
                req_off_r     <= ex_addr[1:0];
                req_uns_r     <= ex_mem_unsigned;
                req_pc_r      <= ex_pc;
            end else if (done_s) begin
                wb_q_valid       <= 1'b1;
                wb_q_trap_mcause <= 32'd0;
                wb_q_trap_pc     <= req_pc_r;
                wb_q_rd_addr     <= dmem_we ? 5'd0 : req_rd_addr_r;
                wb_q_rd_wdata    <= dmem_we ? 32'd0
                                            : load_ext_f(req_size_r, req_off_r, req_uns_r, dmem_rdata);
                wb_q_csr_addr    <= 12'd0;
                wb_q_csr_wdata   <= 32'd0;
                dmem_req         <= 1'b0;
                dmem_we          <= 1'b0;
            end else begin
                dmem_req <= dmem_req;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed, table-driven bench for mem_stage: single-cycle vectors from a table plus
// hand-written bus, reset and (with DMEM_TIMEOUT_EN) timeout sequences.
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        ex_valid, ex_mem_rd, ex_mem_wr, ex_mem_unsigned, ex_trap_valid;
    logic [1:0]  ex_mem_size;
    logic [31:0] ex_addr, ex_store_data, ex_csr_wdata, ex_trap_mcause, ex_pc;
    logic [4:0]  ex_rd_addr;
    logic [11:0] ex_csr_addr;
    logic        mem_stall, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        wb_q_valid, wb_q_trap_valid;
    logic [31:0] wb_q_trap_mcause, wb_q_trap_pc, wb_q_rd_wdata, wb_q_csr_wdata;
    logic [4:0]  wb_q_rd_addr;
    logic [11:0] wb_q_csr_addr;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
        .ex_mem_size(ex_mem_size), .ex_mem_unsigned(ex_mem_unsigned),
        .ex_addr(ex_addr), .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
        .ex_csr_addr(ex_csr_addr), .ex_csr_wdata(ex_csr_wdata),
        .ex_trap_valid(ex_trap_valid), .ex_trap_mcause(ex_trap_mcause), .ex_pc(ex_pc),
        .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_q_valid(wb_q_valid), .wb_q_trap_valid(wb_q_trap_valid),
        .wb_q_trap_mcause(wb_q_trap_mcause), .wb_q_trap_pc(wb_q_trap_pc),
        .wb_q_rd_wdata(wb_q_rd_wdata), .wb_q_csr_wdata(wb_q_csr_wdata),
        .wb_q_rd_addr(wb_q_rd_addr), .wb_q_csr_addr(wb_q_csr_addr)
    );

    typedef struct {
        logic        v, rd, wr, uns, tv;
        logic [1:0]  size;
        logic [31:0] addr, sdata, cause, pc, cwd;
        logic [4:0]  rda;
        logic [11:0] ca;
    } ex_t;

    typedef struct {
        string       nm;
        ex_t         e;
        logic        tv;
        logic [31:0] cause, rdw, cwd;
        logic [4:0]  rda;
        logic [11:0] ca;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    ex_t  idle_ex, junk_ex;
    vec_t vecs[10];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic ex_t mk(input logic v, input logic rd, input logic wr, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr, input logic [31:0] sdata,
                               input logic [4:0] rda, input logic tv, input logic [31:0] cause,
                               input logic [31:0] pc, input logic [11:0] ca, input logic [31:0] cwd);
        ex_t e;
        e.v = v; e.rd = rd; e.wr = wr; e.size = size; e.uns = uns; e.addr = addr;
        e.sdata = sdata; e.rda = rda; e.tv = tv; e.cause = cause; e.pc = pc; e.ca = ca; e.cwd = cwd;
        return e;
    endfunction

    function automatic vec_t mkv(input string nm, input ex_t e, input logic tv, input logic [31:0] cause,
                                 input logic [4:0] rda, input logic [31:0] rdw,
                                 input logic [11:0] ca, input logic [31:0] cwd);
        vec_t v;
        v.nm = nm; v.e = e; v.tv = tv; v.cause = cause; v.rda = rda; v.rdw = rdw; v.ca = ca; v.cwd = cwd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input ex_t e);
        ex_valid = e.v; ex_mem_rd = e.rd; ex_mem_wr = e.wr; ex_mem_size = e.size;
        ex_mem_unsigned = e.uns; ex_addr = e.addr; ex_store_data = e.sdata; ex_rd_addr = e.rda;
        ex_trap_valid = e.tv; ex_trap_mcause = e.cause; ex_pc = e.pc;
        ex_csr_addr = e.ca; ex_csr_wdata = e.cwd;
    endtask

    // One bus transaction acked on the waitc-th BUSY cycle; ALU junk is driven while busy
    task automatic mem_op(input string nm, input ex_t e, input int waitc, input logic [31:0] rdata,
                          input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wdata, input logic [4:0] exp_rd,
                          input logic [31:0] exp_rdw);
        int stalls;
        stalls = 0;
        @(negedge clk); drive(e);
        @(posedge clk); #1;
        chk({nm, "_req"}, {31'd0, dmem_req}, 32'd1);
        chk({nm, "_we"}, {31'd0, dmem_we}, {31'd0, e.wr});
        chk({nm, "_addr"}, dmem_addr, exp_addr);
        chk({nm, "_wbv0"}, {31'd0, wb_q_valid}, 32'd0);
        if (e.wr) begin
            chk({nm, "_strb"}, {28'd0, dmem_wstrb}, {28'd0, exp_strb});
            chk({nm, "_wdata"}, dmem_wdata, exp_wdata);
        end
        for (int c = 1; c <= waitc; c++) begin
            @(negedge clk);
            drive(junk_ex);
            dmem_ack   = (c == waitc);
            dmem_rdata = (c == waitc) ? rdata : 32'h5A5A_5A5A;
            if (mem_stall && dmem_req && dmem_addr === exp_addr) stalls++;
            @(posedge clk); #1;
            if (c < waitc) chk({nm, "_busy_wbv"}, {31'd0, wb_q_valid}, 32'd0);
        end
        chk({nm, "_stalls"}, stalls, waitc);
        chk({nm, "_wbv"}, {31'd0, wb_q_valid}, 32'd1);
        chk({nm, "_trapv"}, {31'd0, wb_q_trap_valid}, 32'd0);
        chk({nm, "_rd"}, {27'd0, wb_q_rd_addr}, {27'd0, exp_rd});
        if (!e.wr) chk({nm, "_rdw"}, wb_q_rd_wdata, exp_rdw);
        chk({nm, "_stall_end"}, {31'd0, mem_stall}, 32'd0);
        chk({nm, "_req_end"}, {31'd0, dmem_req}, 32'd0);
        @(negedge clk);
        dmem_ack = 1'b0;
        drive(idle_ex);
    endtask

`ifdef DMEM_TIMEOUT_EN
    task automatic timeout_op(input string nm, input ex_t e, input logic [31:0] exp_cause);
        int stalls;
        stalls = 0;
        @(negedge clk); drive(e);
        @(posedge clk); #1;
        chk({nm, "_req"}, {31'd0, dmem_req}, 32'd1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            drive(junk_ex);
            if (mem_stall && dmem_req) stalls++;
            @(posedge clk); #1;
            if (c < 4) chk({nm, "_busy_wbv"}, {31'd0, wb_q_valid}, 32'd0);
        end
        chk({nm, "_stalls"}, stalls, 32'd4);
        chk({nm, "_trapv"}, {31'd0, wb_q_trap_valid}, 32'd1);
        chk({nm, "_cause"}, wb_q_trap_mcause, exp_cause);
        chk({nm, "_pc"}, wb_q_trap_pc, e.pc);
        chk({nm, "_rd"}, {27'd0, wb_q_rd_addr}, 32'd0);
        chk({nm, "_req_end"}, {31'd0, dmem_req}, 32'd0);
        chk({nm, "_stall_end"}, {31'd0, mem_stall}, 32'd0);
        @(negedge clk); drive(idle_ex);
    endtask
`endif

    initial begin
        idle_ex = mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0, 12'd0, 32'd0);
        junk_ex = mk(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0BAD, 32'd0, 5'd9, 1'b0, 32'd0,
                     32'h0000_0990, 12'h123, 32'h0000_0456);
        // name, inputs(v rd wr size uns addr sdata rd tv cause pc csr csrw), exp tv cause rd rdw csr csrw
        vecs[0] = mkv("alu0", mk(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_1234, 32'd0, 5'd5, 1'b0, 32'd0,
                      32'h0000_0100, 12'h300, 32'h0000_DEAD), 1'b0, 32'd0, 5'd5, 32'h0000_1234, 12'h300, 32'h0000_DEAD);
        vecs[1] = mkv("alu1", mk(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'd0, 5'd31, 1'b0, 32'd0,
                      32'h0000_0104, 12'h7FF, 32'h0000_0001), 1'b0, 32'd0, 5'd31, 32'hFFFF_FFFF, 12'h7FF, 32'h0000_0001);
        vecs[2] = mkv("lw_mis", mk(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'd0, 5'd1, 1'b0, 32'd0,
                      32'h0000_0200, 12'h341, 32'h0000_0011), 1'b1, 32'd4, 5'd0, 32'd0, 12'd0, 32'd0);
        vecs[3] = mkv("lh_mis", mk(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0103, 32'd0, 5'd2, 1'b0, 32'd0,
                      32'h0000_0204, 12'h342, 32'h0000_0022), 1'b1, 32'd4, 5'd0, 32'd0, 12'd0, 32'd0);
        vecs[4] = mkv("sw_mis", mk(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0102, 32'h1111_2222, 5'd3, 1'b0,
                      32'd0, 32'h0000_0208, 12'h343, 32'h0000_0033), 1'b1, 32'd6, 5'd0, 32'd0, 12'd0, 32'd0);
        vecs[5] = mkv("sh_mis", mk(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0105, 32'h0000_3333, 5'd4, 1'b0,
                      32'd0, 32'h0000_020C, 12'h344, 32'h0000_0044), 1'b1, 32'd6, 5'd0, 32'd0, 12'd0, 32'd0);
        vecs[6] = mkv("sz11_mis", mk(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0102, 32'd0, 5'd6, 1'b0, 32'd0,
                      32'h0000_0210, 12'h345, 32'h0000_0055), 1'b1, 32'd4, 5'd0, 32'd0, 12'd0, 32'd0);
        vecs[7] = mkv("up_mis", mk(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'd0, 5'd7, 1'b1,
                      32'h0000_0002, 32'h0000_0214, 12'h346, 32'h0000_0066), 1'b1, 32'h0000_0002, 5'd0, 32'd0, 12'd0, 32'd0);
        vecs[8] = mkv("up_sw", mk(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'h7777_8888, 5'd8, 1'b1,
                      32'h8000_000B, 32'h0000_0218, 12'h347, 32'h0000_0077), 1'b1, 32'h8000_000B, 5'd0, 32'd0, 12'd0, 32'd0);
        vecs[9] = mkv("up_alu", mk(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_5555, 32'd0, 5'd10, 1'b1,
                      32'h0000_0003, 32'h0000_021C, 12'h348, 32'h0000_0088), 1'b1, 32'h0000_0003, 5'd0, 32'd0, 12'd0, 32'd0);

        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        drive(vecs[0].e);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wbv", {31'd0, wb_q_valid}, 32'd0);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_stall", {31'd0, mem_stall}, 32'd0);
        chk("rst_rdw", wb_q_rd_wdata, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("first_wbv", {31'd0, wb_q_valid}, 32'd1);
        chk("first_rd", {27'd0, wb_q_rd_addr}, 32'd5);
        chk("first_rdw", wb_q_rd_wdata, 32'h0000_1234);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk); drive(vecs[i].e);
            @(posedge clk); #1;
            chk({vecs[i].nm, "_trapv"}, {31'd0, wb_q_trap_valid}, {31'd0, vecs[i].tv});
            chk({vecs[i].nm, "_req"}, {31'd0, dmem_req}, 32'd0);
            chk({vecs[i].nm, "_stall"}, {31'd0, mem_stall}, 32'd0);
            chk({vecs[i].nm, "_rd"}, {27'd0, wb_q_rd_addr}, {27'd0, vecs[i].rda});
            chk({vecs[i].nm, "_csr"}, {20'd0, wb_q_csr_addr}, {20'd0, vecs[i].ca});
            chk({vecs[i].nm, "_csrw"}, wb_q_csr_wdata, vecs[i].cwd);
            if (vecs[i].tv) begin
                chk({vecs[i].nm, "_cause"}, wb_q_trap_mcause, vecs[i].cause);
                chk({vecs[i].nm, "_pc"}, wb_q_trap_pc, vecs[i].e.pc);
            end else begin
                chk({vecs[i].nm, "_wbv"}, {31'd0, wb_q_valid}, 32'd1);
                chk({vecs[i].nm, "_rdw"}, wb_q_rd_wdata, vecs[i].rdw);
            end
        end
        @(negedge clk); drive(idle_ex);

        mem_op("lb", mk(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'd0, 5'd7, 1'b0, 32'd0, 32'h40, 12'd0, 32'd0),
               3, 32'h80FF_FFFF, 32'h0000_0100, 4'b1000, 32'd0, 5'd7, 32'hFFFF_FF80);
        mem_op("lbu", mk(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'd0, 5'd7, 1'b0, 32'd0, 32'h44, 12'd0, 32'd0),
               3, 32'h80FF_FFFF, 32'h0000_0100, 4'b1000, 32'd0, 5'd7, 32'h0000_0080);
        mem_op("sh", mk(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h0000_ABCD, 5'd9, 1'b0, 32'd0, 32'h48, 12'd0, 32'd0),
               1, 32'd0, 32'h0000_0100, 4'b1100, 32'hABCD_ABCD, 5'd0, 32'd0);
        mem_op("lh", mk(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'd0, 5'd11, 1'b0, 32'd0, 32'h4C, 12'd0, 32'd0),
               2, 32'h8001_7FFF, 32'h0000_0100, 4'b1100, 32'd0, 5'd11, 32'hFFFF_8001);
        mem_op("lhu", mk(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0100, 32'd0, 5'd12, 1'b0, 32'd0, 32'h50, 12'd0, 32'd0),
               1, 32'h8001_F00F, 32'h0000_0100, 4'b0011, 32'd0, 5'd12, 32'h0000_F00F);
        mem_op("sb", mk(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h1234_56A5, 5'd13, 1'b0, 32'd0, 32'h54, 12'd0, 32'd0),
               1, 32'd0, 32'h0000_0100, 4'b0010, 32'hA5A5_A5A5, 5'd0, 32'd0);
        mem_op("sw11", mk(1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 32'h0000_0204, 32'hCAFE_F00D, 5'd14, 1'b0, 32'd0, 32'h58, 12'd0, 32'd0),
               2, 32'd0, 32'h0000_0204, 4'b1111, 32'hCAFE_F00D, 5'd0, 32'd0);
`ifdef DMEM_TIMEOUT_EN
        mem_op("lw_lastack", mk(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0208, 32'd0, 5'd15, 1'b0, 32'd0, 32'h5C, 12'd0, 32'd0),
               4, 32'h1234_5678, 32'h0000_0208, 4'b1111, 32'd0, 5'd15, 32'h1234_5678);
        timeout_op("to_lw", mk(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'd0, 5'd16, 1'b0, 32'd0, 32'h60, 12'd0, 32'd0), 32'd5);
        timeout_op("to_sw", mk(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0304, 32'h1, 5'd17, 1'b0, 32'd0, 32'h64, 12'd0, 32'd0), 32'd7);
`else
        mem_op("lw_long", mk(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0208, 32'd0, 5'd15, 1'b0, 32'd0, 32'h5C, 12'd0, 32'd0),
               10, 32'h1234_5678, 32'h0000_0208, 4'b1111, 32'd0, 5'd15, 32'h1234_5678);
`endif

        // Reset asserted in the middle of a bus wait
        @(negedge clk); drive(mk(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0077, 32'd0, 5'd3, 1'b0, 32'd0, 32'h70, 12'd0, 32'd0));
        @(posedge clk); #1;
        chk("pre_rst_rdw", wb_q_rd_wdata, 32'h0000_0077);
        @(negedge clk); drive(mk(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'd0, 5'd4, 1'b0, 32'd0, 32'h74, 12'd0, 32'd0));
        @(posedge clk); #1;
        chk("midrst_busy", {31'd0, mem_stall}, 32'd1);
        @(negedge clk); drive(junk_ex);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_req", {31'd0, dmem_req}, 32'd0);
        chk("midrst_stall", {31'd0, mem_stall}, 32'd0);
        chk("midrst_addr", dmem_addr, 32'd0);
        chk("midrst_rdw", wb_q_rd_wdata, 32'd0);
        chk("midrst_rd", {27'd0, wb_q_rd_addr}, 32'd0);
        @(posedge clk); #1;
        chk("midrst_hold", {31'd0, wb_q_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(vecs[0].e);
        @(posedge clk); #1;
        chk("postrst_wbv", {31'd0, wb_q_valid}, 32'd1);
        chk("postrst_rdw", wb_q_rd_wdata, 32'h0000_1234);
        chk("postrst_stall", {31'd0, mem_stall}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
